// File: rtl/uop_issue_queue.sv
// Circular micro-op issue queue between the decoder and the backend.
// Optional statistics counters are enabled with `define UOP_ISSUE_QUEUE_STATS_EN.
package uop_issue_queue_pkg;
  typedef enum logic [3:0] {
    UOP_INT_ALU  = 4'd0,
    UOP_INT_MUL  = 4'd1,
    UOP_LD_U8    = 4'd2,
    UOP_ST_U8    = 4'd3,
    UOP_CAP_JUMP = 4'd4,
    UOP_LINK     = 4'd5,
    UOP_BRANCH   = 4'd6,
    UOP_CSR      = 4'd7
  } uop_tag_t;
endpackage

module uop_issue_queue
  import uop_issue_queue_pkg::*;
#(
  parameter int MAX_UOPS = 2,
  parameter int ISSUE_W  = 2,
  parameter int DEPTH    = 8,
  parameter int CNT_W    = $clog2(MAX_UOPS + 1),
  parameter int OCC_W    = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic               in_match_i,
  input  logic [CNT_W-1:0]   in_count_i,
  input  uop_tag_t           in_tags_i [MAX_UOPS],
  output logic [ISSUE_W-1:0] out_valid_o,
  output uop_tag_t           out_tags_o [ISSUE_W],
  input  logic               out_ready_i,
  input  logic               flush_i,
  output logic               illegal_o,
`ifdef UOP_ISSUE_QUEUE_STATS_EN
  output logic [31:0]        stat_enq_uops_o,
  output logic [31:0]        stat_full_cycles_o,
  output logic [15:0]        stat_miss_o,
`endif
  output logic [OCC_W-1:0]   occupancy_o
);

  localparam int PTR_W = $clog2(DEPTH);

  uop_tag_t             mem [DEPTH];
  logic [PTR_W-1:0]     head_reg, tail_reg, head_next, tail_next;
  logic [OCC_W-1:0]     occ_reg, occ_next;
  logic                 illegal_reg;
  logic [ISSUE_W-1:0]   out_valid_reg, out_valid_next;
  uop_tag_t             out_tags_reg [ISSUE_W];
  uop_tag_t             out_tags_next [ISSUE_W];

  logic                 enq_fire, miss_fire, deq_fire;
  logic [CNT_W-1:0]     cnt_clamped;
  logic [OCC_W-1:0]     enq_cnt, deq_cnt;
  logic [MAX_UOPS-1:0]  wr_en;
  logic [PTR_W-1:0]     wr_idx [MAX_UOPS];

  assign in_ready_o = (occ_reg <= OCC_W'(DEPTH - MAX_UOPS));
  assign enq_fire   = in_valid_i & in_ready_o & in_match_i & ~flush_i;
  assign miss_fire  = in_valid_i & in_ready_o & ~in_match_i & ~flush_i;
  assign deq_fire   = out_ready_i & out_valid_reg[0] & ~flush_i;

  assign cnt_clamped = (in_count_i > CNT_W'(MAX_UOPS)) ? CNT_W'(MAX_UOPS) : in_count_i;
  assign enq_cnt     = enq_fire ? OCC_W'(cnt_clamped) : '0;
  assign deq_cnt     = !deq_fire ? '0 :
                       (occ_reg < OCC_W'(ISSUE_W)) ? occ_reg : OCC_W'(ISSUE_W);

  assign occ_next  = flush_i ? '0 : occ_reg + enq_cnt - deq_cnt;
  assign head_next = flush_i ? '0 : head_reg + PTR_W'(deq_cnt);
  assign tail_next = flush_i ? '0 : tail_reg + PTR_W'(enq_cnt);

  generate
    for (genvar gi = 0; gi < MAX_UOPS; gi++) begin : g_wr
      assign wr_en[gi]  = enq_fire && (CNT_W'(gi) < cnt_clamped);
      assign wr_idx[gi] = tail_reg + PTR_W'(gi);
    end

    // Output lanes are precomputed from next-state so they can be registered;
    // entries written this cycle are forwarded into the register, not to the port.
    for (genvar gi = 0; gi < ISSUE_W; gi++) begin : g_rd
      logic [PTR_W-1:0] rd_idx;
      uop_tag_t         lane_tag;
      assign rd_idx = head_next + PTR_W'(gi);
      always_comb begin
        lane_tag = mem[rd_idx];
        for (int j = 0; j < MAX_UOPS; j++) begin
          if (wr_en[j] && (wr_idx[j] == rd_idx)) lane_tag = in_tags_i[j];
        end
      end
      assign out_valid_next[gi] = (occ_next > OCC_W'(gi));
      assign out_tags_next[gi]  = out_valid_next[gi] ? lane_tag : UOP_INT_ALU;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int j = 0; j < MAX_UOPS; j++) begin
        if (wr_en[j]) mem[wr_idx[j]] <= in_tags_i[j];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_reg      <= '0;
      tail_reg      <= '0;
      occ_reg       <= '0;
      illegal_reg   <= 1'b0;
      out_valid_reg <= '0;
      for (int k = 0; k < ISSUE_W; k++) out_tags_reg[k] <= UOP_INT_ALU;
    end else begin
      head_reg      <= head_next;
      tail_reg      <= tail_next;
      occ_reg       <= occ_next;
      out_valid_reg <= out_valid_next;
      for (int k = 0; k < ISSUE_W; k++) out_tags_reg[k] <= out_tags_next[k];
      if (flush_i)        illegal_reg <= 1'b0;
      else if (miss_fire) illegal_reg <= 1'b1;
    end
  end

  assign out_valid_o = out_valid_reg;
  assign out_tags_o  = out_tags_reg;
  assign illegal_o   = illegal_reg;
  assign occupancy_o = occ_reg;

`ifdef UOP_ISSUE_QUEUE_STATS_EN
  logic [31:0] stat_enq_reg, stat_full_reg;
  logic [15:0] stat_miss_reg;
  logic [32:0] enq_sum;

  assign enq_sum = {1'b0, stat_enq_reg} + 33'(enq_cnt);

  // Counters saturate and survive flush; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_enq_reg  <= '0;
      stat_full_reg <= '0;
      stat_miss_reg <= '0;
    end else begin
      stat_enq_reg <= enq_sum[32] ? '1 : enq_sum[31:0];
      if (in_valid_i && !in_ready_o && (stat_full_reg != '1)) stat_full_reg <= stat_full_reg + 32'd1;
      if (miss_fire && (stat_miss_reg != '1)) stat_miss_reg <= stat_miss_reg + 16'd1;
    end
  end

  assign stat_enq_uops_o    = stat_enq_reg;
  assign stat_full_cycles_o = stat_full_reg;
  assign stat_miss_o        = stat_miss_reg;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i) assert (occ_reg <= OCC_W'(DEPTH));
  end
`endif

endmodule
